// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 target that swaps one received word for one preloaded response word
// SCLK/CS_N/MOSI are oversampled in the clk domain; all SPI actions follow a synced edge.
module spi_slave_responder #(
    parameter int          WORD_W     = 32,
    parameter logic [31:0] DEFAULT_TX = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err
);
    localparam int CW = $clog2(WORD_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sclk_q, cs_q;
    logic [1:0]        mosi_q;
    logic [1:0]        warm_q, warm_d;
    logic              armed_q, armed_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              frame_err_q, frame_err_d;

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [WORD_W-1:0] next_word;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign mosi_s    = mosi_q[1];
    assign next_word = buf_valid_q ? buf_q : DEFAULT_TX[WORD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= 3'b000;
            cs_q        <= 3'b111;
            mosi_q      <= 2'b00;
            warm_q      <= 2'd0;
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], spi_sclk};
            cs_q        <= {cs_q[1:0], spi_cs_n};
            mosi_q      <= {mosi_q[0], spi_mosi};
            warm_q      <= warm_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        armed_d     = armed_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;

        // The synchroniser holds its reset value for two cycles; only real CS_N=1 may arm.
        if (cs_q[1] && warm_q[1])
            armed_d = 1'b1;

        // Capture and consume are exclusive: capture needs an empty buffer, consume a full one.
        if (tx_valid && !buf_valid_q) begin
            buf_d       = tx_data;
            buf_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (cs_fall && armed_q) begin
                    tx_shift_d = next_word;
                    if (buf_valid_q) buf_valid_d = 1'b0;
                    else             underrun_d  = 1'b1;
                    miso_d    = next_word[WORD_W-1];
                    oe_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    if (bit_cnt_q != '0) frame_err_d = 1'b1;
                    oe_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_s};
                    if (bit_cnt_q == CW'(WORD_W - 1)) begin
                        rx_data_d  = {rx_shift_q[WORD_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = next_word;
                        if (buf_valid_q) buf_valid_d = 1'b0;
                        else             underrun_d  = 1'b1;
                        miso_d = next_word[WORD_W-1];
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[WORD_W-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~buf_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed table-driven bench for spi_slave_responder
module tb_spi_slave_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, tx_underrun, frame_err;

    int n_pass = 0;
    int n_tot  = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    int fe_cnt  = 0;

    spi_slave_responder #(.WORD_W(32), .DEFAULT_TX(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt <= rxv_cnt + 1;
        if (tx_underrun) und_cnt <= und_cnt + 1;
        if (frame_err)   fe_cnt  <= fe_cnt + 1;
    end

    typedef struct {
        logic        pre;
        logic [31:0] txw;
        logic [31:0] mosi;
        logic [31:0] exp_miso;
        logic [31:0] exp_rx;
        int          exp_und;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic preload(input logic [31:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tot++;
            $display("FAIL preload_timeout: tx_ready stuck at %b expected 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // mode 0: plain; mode 1: feed w1 as soon as tx_ready rises; mode 2: release a held tx_valid after the lead-in.
    task automatic xfer(input int nbits, input logic [31:0] w0, input logic [31:0] w1, input int mode,
                        output logic [31:0] m0, output logic [31:0] m1, output int ready_hi,
                        output logic oe_after);
        logic        sent;
        logic [31:0] wd;
        sent     = 1'b0;
        ready_hi = 0;
        m0       = '0;
        m1       = '0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tx_ready) ready_hi++;
            if (mode == 1) begin
                if (tx_valid) tx_valid = 1'b0;
                else if (tx_ready && !sent) begin
                    tx_data  = w1;
                    tx_valid = 1'b1;
                    sent     = 1'b1;
                end
            end
        end
        tx_valid = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            wd       = (b < 32) ? w0 : w1;
            spi_mosi = wd[31 - (b % 32)];
            repeat (4) @(negedge clk);
            if (b < 32) m0 = {m0[30:0], spi_miso};
            else        m1 = {m1[30:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            if (b == nbits - 1) spi_cs_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        oe_after = spi_miso_oe;
        repeat (8) @(negedge clk);
    endtask

    task automatic sclk_pulse(input logic m);
        spi_mosi = m;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    initial begin
        logic [31:0] m0, m1;
        int          rdy, r0, u0, f0;
        logic        oe_a;

        vt[0] = '{1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32'hA5A5_0F0F, 32'h1234_5678, 0};
        vt[1] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1};
        vt[2] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        vt[3] = '{1'b1, 32'h8000_0001, 32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFE, 0};

        rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("rst_miso_oe", {31'b0, spi_miso_oe}, 32'd0);
        chk("rst_miso", {31'b0, spi_miso}, 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_pulses", {29'b0, rx_valid, tx_underrun, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            if (vt[v].pre) preload(vt[v].txw);
            r0 = rxv_cnt; u0 = und_cnt; f0 = fe_cnt;
            xfer(32, vt[v].mosi, 32'h0, 0, m0, m1, rdy, oe_a);
            chk($sformatf("v%0d_miso", v), m0, vt[v].exp_miso);
            chk($sformatf("v%0d_rx_data", v), rx_data, vt[v].exp_rx);
            chk($sformatf("v%0d_rx_valid_cnt", v), rxv_cnt - r0, 32'd1);
            chk($sformatf("v%0d_underrun_cnt", v), und_cnt - u0, vt[v].exp_und);
            chk($sformatf("v%0d_frame_err_cnt", v), fe_cnt - f0, 32'd0);
            chk($sformatf("v%0d_ready_at_start", v), {31'b0, rdy > 0}, 32'd1);
        end

        // Two words in one frame; second word supplied once the first is consumed.
        preload(32'h1111_1111);
        r0 = rxv_cnt; u0 = und_cnt; f0 = fe_cnt;
        xfer(64, 32'h0BAD_F00D, 32'h2222_2222, 1, m0, m1, rdy, oe_a);
        chk("two_miso_w0", m0, 32'h1111_1111);
        chk("two_miso_w1", m1, 32'h2222_2222);
        chk("two_rx_valid_cnt", rxv_cnt - r0, 32'd2);
        chk("two_underrun_cnt", und_cnt - u0, 32'd0);
        chk("two_rx_data", rx_data, 32'h2222_2222);

        // Abort after 13 SCLKs.
        r0 = rxv_cnt; u0 = und_cnt; f0 = fe_cnt;
        xfer(13, 32'h1357_9BDF, 32'h0, 0, m0, m1, rdy, oe_a);
        chk("abort_frame_err_cnt", fe_cnt - f0, 32'd1);
        chk("abort_rx_valid_cnt", rxv_cnt - r0, 32'd0);
        chk("abort_rx_data_kept", rx_data, 32'h2222_2222);
        chk("abort_oe_off", {31'b0, oe_a}, 32'd0);

        // tx_valid held high across the consume cycle.
        preload(32'h0F0F_0F0F);
        tx_data  = 32'h3C3C_3C3C;
        tx_valid = 1'b1;
        r0 = rxv_cnt; u0 = und_cnt; f0 = fe_cnt;
        xfer(64, 32'h5555_AAAA, 32'hAAAA_5555, 2, m0, m1, rdy, oe_a);
        chk("hold_ready_cycles", rdy, 32'd1);
        chk("hold_miso_w0", m0, 32'h0F0F_0F0F);
        chk("hold_miso_w1", m1, 32'h3C3C_3C3C);
        chk("hold_underrun_cnt", und_cnt - u0, 32'd0);
        chk("hold_rx_data", rx_data, 32'hAAAA_5555);

        // Reset mid-frame with CS_N held low afterwards.
        r0 = rxv_cnt; f0 = fe_cnt;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) sclk_pulse(i[0]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) sclk_pulse(~i[0]);
        chk("rstmid_oe_off", {31'b0, spi_miso_oe}, 32'd0);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstmid_rx_valid_cnt", rxv_cnt - r0, 32'd0);
        chk("rstmid_rx_data_reset", rx_data, 32'd0);
        r0 = rxv_cnt;
        xfer(32, 32'hDEAD_BEEF, 32'h0, 0, m0, m1, rdy, oe_a);
        chk("after_rst_rx_data", rx_data, 32'hDEAD_BEEF);
        chk("after_rst_rx_valid_cnt", rxv_cnt - r0, 32'd1);
        chk("after_rst_miso", m0, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI target (slave) endpoint that answers the 32-bit SPI initiator used on the peripheral-command path. Mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples SCLK, MOSI and CS_N in the system clock domain. Shifts one received word in while shifting one response word out, then presents the received word on a valid pulse.
- A response word is preloaded through a valid/ready handshake, so the next frame carries it.

Parameters:
- WORD_W, 32, bits per SPI word; legal range 8..32.
- DEFAULT_TX, 32'hFFFF_FFFF, word sent when no response was preloaded; low WORD_W bits used.

Ports:
- clk  in  1  system clock; must be at least 8x SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from initiator, asynchronous.
- spi_cs_n  in  1  chip select from initiator, active low, asynchronous.
- spi_mosi  in  1  serial data from initiator.
- spi_miso  out  1  serial data to initiator.
- spi_miso_oe  out  1  MISO output enable; 1 only while selected.
- tx_data  in  WORD_W  response word to preload.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  preload buffer empty.
- rx_data  out  WORD_W  last complete received word.
- rx_valid  out  1  one-cycle pulse; rx_data updated.
- tx_underrun  out  1  one-cycle pulse; a word started with an empty buffer, so DEFAULT_TX was sent.
- frame_err  out  1  one-cycle pulse; CS_N deasserted mid-word.

Behaviour:
- Synchronisation
  - SCLK, CS_N and MOSI each pass through a 2-flop synchroniser, plus a third flop for edge detection.
  - Sync flops reset to SCLK=0, CS_N=1, MOSI=0.
  - Edge-to-action latency is 3 clk.
- Reset values
  - spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0.
  - bit_cnt=0, buffer empty, state=IDLE, armed=0.
- Arming
  - armed is set whenever synced CS_N=1.
  - A frame starts only on a synced CS_N falling edge while armed=1. A CS_N already held low through reset is therefore ignored until it goes high once.
- Preload buffer
  - tx_ready = !buf_valid.
  - tx_valid && tx_ready captures tx_data and sets buf_valid.
  - When a word load consumes the buffer, buf_valid clears in the same cycle. A tx_valid in that cycle is not captured, because tx_ready was 0.
- State IDLE
  - spi_miso_oe=0.
  - On CS_N falling edge (armed): load tx_shift from the buffer (consume it) or from DEFAULT_TX (pulse tx_underrun), set spi_miso = MSB, spi_miso_oe=1, bit_cnt=0, go to ACTIVE.
- State ACTIVE, SCLK rising edge
  - rx_shift <= {rx_shift[WORD_W-2:0], mosi_s}.
  - If bit_cnt==WORD_W-1: rx_data <= the completed word, pulse rx_valid next cycle-edge, bit_cnt <= 0.
  - Otherwise bit_cnt++.
- State ACTIVE, SCLK falling edge
  - If bit_cnt==0 (a word just completed): load the next word (buffer or DEFAULT_TX with tx_underrun) and drive its MSB. This supports back-to-back words in one CS frame.
  - Otherwise tx_shift <<= 1 and spi_miso <= next bit.
- State ACTIVE, CS_N rising edge
  - Takes priority over any SCLK edge in the same cycle.
  - If bit_cnt!=0: pulse frame_err; the partial word is discarded and rx_data is unchanged.
  - spi_miso_oe <= 0, go to IDLE.
  - A word already loaded but not shifted is dropped; the buffer is not restored.
- SCLK edges while in IDLE are ignored.
- rx_valid has no backpressure; a consumer must take rx_data within WORD_W SCLK periods.
- Reset asserted mid-frame returns to reset values immediately. The remaining bits of that frame are ignored (armed=0).

Test Plan:
- Preload 32'hA5A5_0F0F, initiator sends 32'h1234_5678 at clk/8 -> MISO stream reads A5A50F0F; rx_data=32'h12345678 with a single rx_valid pulse; tx_ready returns to 1 at frame start.
- No preload, initiator sends 32'h0000_0001 -> MISO=32'hFFFFFFFF, tx_underrun pulses once, rx_data=1.
- Two words in one CS frame (preload 32'h1111_1111, then 32'h2222_2222 when tx_ready rises) -> MISO carries both in order; two rx_valid pulses, no tx_underrun.
- CS_N raised after 13 SCLKs -> frame_err pulses once, rx_valid=0, rx_data keeps its previous value, spi_miso_oe=0 within 3 clk.
- rst pulsed while CS_N is low mid-frame, CS_N kept low with 20 more SCLKs -> no rx_valid. The next CS_N high-then-low frame with 32'hDEAD_BEEF gives rx_data=32'hDEADBEEF.
- tx_valid held high during the cycle the buffer is consumed -> that data is not captured in that cycle and is captured on the next cycle when tx_ready=1.
